rs_entry_alloc: RTL

//  Free-entry allocator for one reservation station. Tracks a busy bitmap of ENT_NUM

---
 rtl/rs_entry_alloc_pkg.sv | 11 +
 rtl/rs_entry_alloc_chk.sv | 33 +++
 rtl/rs_entry_alloc_prio_enc_lsb.sv | 30 +++
 rtl/rs_entry_alloc.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/rs_entry_alloc_pkg.sv
// Shared constants for the reservation-station allocator slice.
//   RS_ENT_NUM     : number of reservation-station entries (power of 2, >= 4)
//   RS_ENT_SEL     : entry index width
//   DISPATCH_WIDTH : dispatch slots served per cycle
package rs_entry_alloc_pkg;

  localparam int RS_ENT_NUM     = 8;
  localparam int RS_ENT_SEL     = $clog2(RS_ENT_NUM);
  localparam int DISPATCH_WIDTH = 2;

endpackage : rs_entry_alloc_pkg

// File: rtl/rs_entry_alloc_chk.sv
// Simulation checker for rs_entry_alloc. Assertions only, no logic.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   alloc_req   : dispatch slot requests
//   free_mask   : entries released by issue this cycle
//   busy        : current busy bitmap
//   alloc_ack   : grants issued this cycle
module rs_entry_alloc_chk
  import rs_entry_alloc_pkg::*;
#(
  parameter int ENT_NUM = RS_ENT_NUM
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic [DISPATCH_WIDTH-1:0] alloc_req,
  input logic [ENT_NUM-1:0]        free_mask,
  input logic [ENT_NUM-1:0]        busy,
  input logic [DISPATCH_WIDTH-1:0] alloc_ack
);

  // Slot1 may only request together with the older slot0.
  a_req_in_order : assert property (@(posedge clk) disable iff (!rst_n)
    alloc_req != 2'b10);

  // Issue must only release entries that are actually allocated.
  a_free_busy_only : assert property (@(posedge clk) disable iff (!rst_n)
    (free_mask & ~busy) == {ENT_NUM{1'b0}});

  // Slot1 is never granted without slot0.
  a_ack_in_order : assert property (@(posedge clk) disable iff (!rst_n)
    !(alloc_ack[1] && !alloc_ack[0]));

endmodule : rs_entry_alloc_chk

// File: rtl/rs_entry_alloc_prio_enc_lsb.sv
// Lowest-set-bit priority encoder.
// Ports:
//   req : request vector, bit 0 has the highest priority
//   idx : index of the lowest set bit, 0 when no bit is set
//   vld : at least one request bit is set
module rs_entry_alloc_prio_enc_lsb
  import rs_entry_alloc_pkg::*;
#(
  parameter int REQ_NUM = RS_ENT_NUM,
  parameter int ACK_SEL = RS_ENT_SEL
) (
  input  logic [REQ_NUM-1:0] req,
  output logic [ACK_SEL-1:0] idx,
  output logic               vld
);

  logic [ACK_SEL-1:0] idx_s;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_s = {ACK_SEL{1'b0}};
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      idx_s = req[i] ? ACK_SEL'(i) : idx_s;
    end
  end

  assign idx = idx_s;
  assign vld = |req;

endmodule : rs_entry_alloc_prio_enc_lsb

// File: rtl/rs_entry_alloc.sv
// Free-entry allocator for one reservation station.
// Keeps a busy bitmap and grants up to two free entries per cycle to
// dispatch, lowest index first. Entries released by issue become
// allocatable the cycle after they are released.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_flush        : clear every entry; no grants that cycle
//   i_alloc_req    : dispatch slot requests, bit 0 = older instruction
//   o_alloc_ack    : combinational grant per slot
//   o_alloc_idx0/1 : granted entry per slot, 0 when not granted
//   i_free_mask    : entries released by issue this cycle
//   o_busy         : registered busy bitmap
//   o_free_cnt     : registered number of free entries
//   o_full         : registered, fewer than two free entries
module rs_entry_alloc
  import rs_entry_alloc_pkg::*;
#(
  parameter int ENT_NUM = RS_ENT_NUM,
  parameter int ENT_SEL = RS_ENT_SEL
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_flush,
  input  logic [DISPATCH_WIDTH-1:0] i_alloc_req,
  output logic [DISPATCH_WIDTH-1:0] o_alloc_ack,
  output logic [ENT_SEL-1:0]        o_alloc_idx0,
  output logic [ENT_SEL-1:0]        o_alloc_idx1,
  input  logic [ENT_NUM-1:0]        i_free_mask,
  output logic [ENT_NUM-1:0]        o_busy,
  output logic [ENT_SEL:0]          o_free_cnt,
  output logic                      o_full
);

  localparam logic [ENT_SEL:0] FREE_CNT_RST = (ENT_SEL + 1)'(ENT_NUM);
  localparam logic [ENT_SEL:0] FULL_THRESH  = (ENT_SEL + 1)'(2);

  logic [ENT_NUM-1:0] busy_r;
  logic [ENT_SEL:0]   free_cnt_r;
  logic               full_r;

  logic [ENT_NUM-1:0] free_vec_s;
  logic [ENT_NUM-1:0] above_mask_s;
  logic [ENT_NUM-1:0] free_above_s;
  logic [ENT_SEL-1:0] free0_idx_s;
  logic [ENT_SEL-1:0] free1_idx_s;
  logic               free0_vld_s;
  logic               free1_vld_s;
  logic               ack0_s;
  logic               ack1_s;
  logic [ENT_NUM-1:0] grant_vec_s;
  logic [ENT_NUM-1:0] busy_nxt_s;
  logic [ENT_SEL:0]   free_cnt_nxt_s;

  // Number of zero bits in a busy bitmap; ENT_SEL+1 bits holds ENT_NUM.
  function automatic logic [ENT_SEL:0] count_free(input logic [ENT_NUM-1:0] busy);
    logic [ENT_SEL:0] cnt;
    cnt = {(ENT_SEL + 1){1'b0}};
    for (int i = 0; i < ENT_NUM; i++) begin
      cnt = cnt + {{ENT_SEL{1'b0}}, ~busy[i]};
    end
    return cnt;
  endfunction

  assign free_vec_s = ~busy_r;

  rs_entry_alloc_prio_enc_lsb #(
    .REQ_NUM (ENT_NUM),
    .ACK_SEL (ENT_SEL)
  ) u_enc0 (
    .req (free_vec_s),
    .idx (free0_idx_s),
    .vld (free0_vld_s)
  );

  // Keep only free entries strictly above the first pick for the second pick.
  always_comb begin
    above_mask_s = {ENT_NUM{1'b0}};
    for (int i = 0; i < ENT_NUM; i++) begin
      above_mask_s[i] = (ENT_SEL'(i) > free0_idx_s);
    end
  end

  assign free_above_s = free_vec_s & above_mask_s;

  rs_entry_alloc_prio_enc_lsb #(
    .REQ_NUM (ENT_NUM),
    .ACK_SEL (ENT_SEL)
  ) u_enc1 (
    .req (free_above_s),
    .idx (free1_idx_s),
    .vld (free1_vld_s)
  );

  // Grant decision. Slot1 depends on ack0, so a lone slot1 request gets nothing.
  always_comb begin
    ack0_s = 1'b0;
    ack1_s = 1'b0;
    if (i_flush) begin
      ack0_s = 1'b0;
      ack1_s = 1'b0;
    end else begin
      ack0_s = i_alloc_req[0] & free0_vld_s;
      ack1_s = i_alloc_req[1] & ack0_s & free1_vld_s;
    end
  end

  assign o_alloc_ack  = {ack1_s, ack0_s};
  assign o_alloc_idx0 = ack0_s ? free0_idx_s : {ENT_SEL{1'b0}};
  assign o_alloc_idx1 = ack1_s ? free1_idx_s : {ENT_SEL{1'b0}};

  // One-hot of every entry granted this cycle.
  always_comb begin
    grant_vec_s = {ENT_NUM{1'b0}};
    for (int i = 0; i < ENT_NUM; i++) begin
      grant_vec_s[i] = (ack0_s && (free0_idx_s == ENT_SEL'(i))) ||
                       (ack1_s && (free1_idx_s == ENT_SEL'(i)));
    end
  end

  // Next busy bitmap; frees of idle entries fall out of the AND harmlessly.
  always_comb begin
    busy_nxt_s = busy_r;
    if (i_flush) begin
      busy_nxt_s = {ENT_NUM{1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~i_free_mask) | grant_vec_s;
    end
  end

  assign free_cnt_nxt_s = count_free(busy_nxt_s);

  // State registers; count and full derive from next busy so they track o_busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_r     <= {ENT_NUM{1'b0}};
      free_cnt_r <= FREE_CNT_RST;
      full_r     <= 1'b0;
    end else begin
      busy_r     <= busy_nxt_s;
      free_cnt_r <= free_cnt_nxt_s;
      full_r     <= (free_cnt_nxt_s < FULL_THRESH);
    end
  end

  assign o_busy     = busy_r;
  assign o_free_cnt = free_cnt_r;
  assign o_full     = full_r;

  rs_entry_alloc_chk #(
    .ENT_NUM (ENT_NUM)
  ) u_chk (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .alloc_req (i_alloc_req),
    .free_mask (i_free_mask),
    .busy      (busy_r),
    .alloc_ack (o_alloc_ack)
  );

endmodule : rs_entry_alloc
